// File: rtl/base_aframe.sv
// base_aframe: cuts an unframed data stream into packets sized by a command stream,
// emitting a registered valid/ready/end stream with a per-packet beat index.
//   state    | meaning
//   S_IDLE   | no packet open; commands accepted, data back-pressured
//   S_ACTIVE | packet open; rem_q beats still to accept
module base_aframe #(
  parameter int width  = 64,
  parameter int lwidth = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_v,
  output logic              i_cmd_r,
  input  logic [lwidth-1:0] i_cmd_len,
  input  logic              i_d_v,
  output logic              i_d_r,
  input  logic [width-1:0]  i_d_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [width-1:0]  o_d,
  output logic              o_e,
  output logic [lwidth-1:0] o_beat
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  // rem carries one extra bit so a zero-length command can hold 2^lwidth.
  localparam logic [lwidth:0] REM_ONE = (lwidth + 1)'(1);
  localparam logic [lwidth:0] REM_MAX = {1'b1, {lwidth{1'b0}}};

  state_t             state_q, state_d;
  logic [lwidth:0]    rem_q, rem_d;
  logic [lwidth-1:0]  idx_q, idx_d;
  logic               o_v_q, o_v_d;
  logic [width-1:0]   o_d_q, o_d_d;
  logic               o_e_q, o_e_d;
  logic [lwidth-1:0]  o_beat_q, o_beat_d;

  logic load_ok, in_x, last_x, cmd_x;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    o_d_d    = o_d_q;
    o_e_d    = o_e_q;
    o_beat_d = o_beat_q;

    load_ok = ~o_v_q | o_r;
    i_d_r   = (state_q == S_ACTIVE) & load_ok;
    in_x    = i_d_v & i_d_r;
    last_x  = in_x & (rem_q == REM_ONE);
    // Opening the next command on the last-beat cycle gives zero-bubble chaining.
    i_cmd_r = (state_q == S_IDLE) | last_x;
    cmd_x   = i_cmd_v & i_cmd_r;

    o_v_d = in_x | (o_v_q & ~o_r);

    if (in_x) begin
      o_d_d    = i_d_d;
      o_e_d    = (rem_q == REM_ONE);
      o_beat_d = idx_q;
      idx_d    = idx_q + 1'b1;
      rem_d    = rem_q - REM_ONE;
    end

    if (last_x) begin
      state_d = S_IDLE;
    end

    if (cmd_x) begin
      rem_d   = (i_cmd_len == '0) ? REM_MAX : {1'b0, i_cmd_len};
      idx_d   = '0;
      state_d = S_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      o_v_q    <= 1'b0;
      o_d_q    <= '0;
      o_e_q    <= 1'b0;
      o_beat_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      o_v_q    <= o_v_d;
      o_d_q    <= o_d_d;
      o_e_q    <= o_e_d;
      o_beat_q <= o_beat_d;
    end
  end

  assign o_v    = o_v_q;
  assign o_d    = o_d_q;
  assign o_e    = o_e_q;
  assign o_beat = o_beat_q;

endmodule

// File: tb/tb_base_aframe.sv
// Bench for base_aframe: packet-level model checked every cycle, plus directed
// packets whose delivered beats are compared against hand-computed literals.
module tb_base_aframe;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cmd_v, i_cmd_r, i_d_v, i_d_r, o_v, o_r, o_e;
  logic [7:0]  i_cmd_len, o_beat;
  logic [15:0] i_d_d, o_d;

  logic        b_cmd_v, b_cmd_r, b_d_v, b_d_r, b_o_v, b_o_r, b_o_e;
  logic [1:0]  b_cmd_len, b_o_beat;
  logic [7:0]  b_d_d, b_o_d;

  always #5 clk = ~clk;

  base_aframe #(.width(16), .lwidth(8)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_v(i_cmd_v), .i_cmd_r(i_cmd_r), .i_cmd_len(i_cmd_len),
    .i_d_v(i_d_v), .i_d_r(i_d_r), .i_d_d(i_d_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_beat(o_beat)
  );

  // Narrow instance so a zero-length command (2^lwidth beats) stays short.
  base_aframe #(.width(8), .lwidth(2)) dut_b (
    .clk(clk), .reset(reset),
    .i_cmd_v(b_cmd_v), .i_cmd_r(b_cmd_r), .i_cmd_len(b_cmd_len),
    .i_d_v(b_d_v), .i_d_r(b_d_r), .i_d_d(b_d_d),
    .o_v(b_o_v), .o_r(b_o_r), .o_d(b_o_d), .o_e(b_o_e), .o_beat(b_o_beat)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus queues consumed by a ready-honouring source.
  int          cmd_q[$];
  logic [15:0] dat_q[$];
  bit          or_q[$];

  typedef struct {logic [15:0] d; logic e; int b; int cyc;} rec_t;
  rec_t log_q[$];

  // Packet-level model: beats owed to the open packet, position in it, held output.
  int          m_left = 0;
  int          m_pos  = 0;
  bit          m_hv   = 0;
  logic [15:0] m_hd   = '0;
  bit          m_he   = 0;
  int          m_hb   = 0;
  int          len_q[$];
  int          cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_o_v", o_v, 0);
      chk("rst_o_d", o_d, 0);
      chk("rst_o_e", o_e, 0);
      chk("rst_o_beat", o_beat, 0);
      chk("rst_cmd_r", i_cmd_r, 1);
      chk("rst_d_r", i_d_r, 0);
      m_left = 0; m_pos = 0; m_hv = 0; m_hd = '0; m_he = 0; m_hb = 0;
      len_q.delete();
      cnt = 0;
    end else begin
      bit can, td, last, tc;
      can  = (m_left > 0) && (!m_hv || o_r);
      td   = can && i_d_v;
      last = td && (m_left == 1);
      tc   = i_cmd_v && ((m_left == 0) || last);
      chk("d_r", i_d_r, can);
      chk("cmd_r", i_cmd_r, (m_left == 0) || last);
      chk("o_v", o_v, m_hv);
      if (m_hv) begin
        chk("o_d", o_d, m_hd);
        chk("o_e", o_e, m_he);
        chk("o_beat", o_beat, m_hb);
      end
      if (o_v && o_r) begin
        log_q.push_back('{d: o_d, e: o_e, b: int'(o_beat), cyc: cyc});
        cnt++;
        if (o_e) begin
          if (len_q.size() == 0) chk("pkt_len_nocmd", 0, 1);
          else chk("pkt_len", cnt, len_q.pop_front());
          cnt = 0;
        end
      end
      if (td) begin
        m_hv = 1; m_hd = i_d_d; m_he = (m_left == 1); m_hb = m_pos % 256;
        m_left--; m_pos++;
      end else if (m_hv && o_r) begin
        m_hv = 0;
      end
      if (tc) begin
        m_left = (i_cmd_len == 0) ? 256 : int'(i_cmd_len);
        m_pos  = 0;
        len_q.push_back(m_left);
      end
    end
  end

  // Source/sink driver: presents queue heads, pops on an observed handshake.
  initial begin
    bit cf, df;
    i_cmd_v = 0; i_cmd_len = '0; i_d_v = 0; i_d_d = '0; o_r = 1'b1;
    forever begin
      @(negedge clk);
      cf = i_cmd_v && i_cmd_r && reset;
      df = i_d_v && i_d_r && reset;
      @(posedge clk); #1;
      if (cf && cmd_q.size() > 0) void'(cmd_q.pop_front());
      if (df && dat_q.size() > 0) void'(dat_q.pop_front());
      i_cmd_v   = cmd_q.size() > 0;
      i_cmd_len = (cmd_q.size() > 0) ? 8'(cmd_q[0]) : 8'h00;
      i_d_v     = dat_q.size() > 0;
      i_d_d     = (dat_q.size() > 0) ? dat_q[0] : 16'h0000;
      o_r       = (or_q.size() > 0) ? or_q.pop_front() : 1'b1;
    end
  end

  task automatic at2();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_q.size() == 0 && dat_q.size() == 0 && or_q.size() == 0 && !m_hv && m_left == 0)
        return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_rec(input string name, input int i, input logic [15:0] d,
                         input logic e, input int b);
    if (i >= log_q.size()) begin
      chk({name, "_missing"}, log_q.size(), i + 1);
    end else begin
      chk({name, "_d"}, log_q[i].d, d);
      chk({name, "_e"}, log_q[i].e, e);
      chk({name, "_b"}, log_q[i].b, b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, seen;
    reset = 1'b0;
    b_cmd_v = 0; b_cmd_len = '0; b_d_v = 0; b_d_d = '0; b_o_r = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // len=0 on a 2-bit length: four beats, end on the fourth
    at2();
    b_cmd_v = 1'b1; b_cmd_len = 2'd0;
    @(negedge clk);
    chk("b_cmd_r_idle", b_cmd_r, 1);
    chk("b_d_r_idle", b_d_r, 0);
    at2();
    b_cmd_v = 1'b0; b_d_v = 1'b1; b_d_d = 8'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_d_r", b_d_r, 1);
      if (k > 0) begin
        chk("b_o_v", b_o_v, 1);
        chk("b_o_d", b_o_d, 8'(8'h10 + k - 1));
        chk("b_o_e", b_o_e, 0);
        chk("b_o_beat", b_o_beat, k - 1);
      end
      at2();
      if (k < 3) b_d_d = 8'(8'h11 + k);
      else b_d_v = 1'b0;
    end
    @(negedge clk);
    chk("b_last_v", b_o_v, 1);
    chk("b_last_d", b_o_d, 8'h13);
    chk("b_last_e", b_o_e, 1);
    chk("b_last_beat", b_o_beat, 3);
    chk("b_after_cmd_r", b_cmd_r, 1);
    chk("b_after_d_r", b_d_r, 0);
    at2();
    @(negedge clk);
    chk("b_drained", b_o_v, 0);

    // single packet len=3, continuous data
    at2();
    base = log_q.size(); c0 = cyc;
    cmd_q.push_back(3);
    dat_q.push_back(16'hA001); dat_q.push_back(16'hB002); dat_q.push_back(16'hC003);
    wait_idle("single", 40);
    chk("single_cnt", log_q.size() - base, 3);
    chk_rec("single0", base + 0, 16'hA001, 0, 0);
    chk_rec("single1", base + 1, 16'hB002, 0, 1);
    chk_rec("single2", base + 2, 16'hC003, 1, 2);
    for (int k = 0; k < 3; k++)
      if (base + k < log_q.size()) chk("single_cyc", log_q[base + k].cyc, c0 + 4 + k);
    @(negedge clk);
    chk("single_cmd_r", i_cmd_r, 1);
    chk("single_d_r", i_d_r, 0);

    // back-to-back len=1 then len=2, no bubble
    at2();
    base = log_q.size(); c0 = cyc;
    cmd_q.push_back(1); cmd_q.push_back(2);
    dat_q.push_back(16'h0111); dat_q.push_back(16'h0222); dat_q.push_back(16'h0333);
    wait_idle("b2b", 40);
    chk("b2b_cnt", log_q.size() - base, 3);
    chk_rec("b2b0", base + 0, 16'h0111, 1, 0);
    chk_rec("b2b1", base + 1, 16'h0222, 0, 0);
    chk_rec("b2b2", base + 2, 16'h0333, 1, 1);
    for (int k = 0; k < 3; k++)
      if (base + k < log_q.size()) chk("b2b_cyc", log_q[base + k].cyc, c0 + 4 + k);

    // backpressure len=4, o_r = 1,0,0 repeating
    at2();
    base = log_q.size();
    for (int k = 0; k < 4; k++) begin
      or_q.push_back(1'b1); or_q.push_back(1'b0); or_q.push_back(1'b0);
    end
    cmd_q.push_back(4);
    for (int k = 0; k < 4; k++) dat_q.push_back(16'(16'h4400 + k));
    wait_idle("bp", 80);
    chk("bp_cnt", log_q.size() - base, 4);
    for (int k = 0; k < 4; k++) chk_rec("bp", base + k, 16'(16'h4400 + k), k == 3, k);
    if (log_q.size() >= base + 4) chk("bp_stalled", (log_q[base + 3].cyc - log_q[base].cyc) > 3, 1);

    // data without a command is held off
    at2();
    base = log_q.size();
    dat_q.push_back(16'hD000); dat_q.push_back(16'hD001);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i_d_r || o_v) seen++;
    end
    chk("nocmd_blocked", seen, 0);
    chk("nocmd_nolog", log_q.size() - base, 0);
    at2();
    cmd_q.push_back(2);
    wait_idle("nocmd", 40);
    chk("nocmd_cnt", log_q.size() - base, 2);
    chk_rec("nocmd0", base + 0, 16'hD000, 0, 0);
    chk_rec("nocmd1", base + 1, 16'hD001, 1, 1);

    // reset in the middle of a len=5 packet
    at2();
    base = log_q.size();
    cmd_q.push_back(5);
    for (int k = 0; k < 5; k++) dat_q.push_back(16'(16'h5000 + k));
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (log_q.size() >= base + 2) seen = 1;
    end
    chk("rstmid_reached", seen, 1);
    at2();
    reset = 1'b0;
    cmd_q.delete(); dat_q.delete(); or_q.delete();
    i_cmd_v = 1'b0; i_d_v = 1'b0;
    @(negedge clk);
    chk("rstmid_o_v", o_v, 0);
    chk("rstmid_o_beat", o_beat, 0);
    at2();
    reset = 1'b1;
    at2();
    base = log_q.size();
    cmd_q.push_back(1);
    dat_q.push_back(16'h5A5A);
    wait_idle("rstmid", 40);
    chk("rstmid_cnt", log_q.size() - base, 1);
    chk_rec("rstmid", base, 16'h5A5A, 1, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
